// File: rtl/mii_ctrl_pkg.sv
// Shared MII control definitions used by the transmit scheduler and the receive side.
package mii_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAM,
    SFD,
    DATA,
    DRAIN,
    IFG
  } mii_state_e;

  localparam logic [7:0] MII_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] MII_SFD_BYTE      = 8'hD5;

  localparam int MII_PREAMBLE_LEN_DEF = 7;
  localparam int MII_IFG_LEN_DEF      = 12;
  localparam int MII_PREAMBLE_CNT_W   = 4;
  localparam int MII_IFG_CNT_W        = 5;

  // One-hot round-robin pick between two requesters; on a tie the requester
  // that did not own the previous frame wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_was_1);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_was_1 ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mii_rr_arb2.sv
// Two-way round-robin frame arbiter; the grant is held for a whole frame.
module mii_rr_arb2 import mii_ctrl_pkg::*; (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       start_i,
  input  logic       release_i,
  output logic [1:0] grant_o
);

  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic [1:0] pick;

  // Candidate owner for a frame starting on this cycle.
  always_comb begin
    pick = rr_pick(req_i, last_q);
  end

  // Latch a new owner at frame start, drop it when the frame and its gap end.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    if (start_i && (pick != 2'b00)) begin
      grant_d = pick;
      last_d  = pick[1];
    end else if (release_i) begin
      grant_d = 2'b00;
    end
  end

  // Owner and round-robin pointer registers; requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: rtl/mii_tx_sched.sv
// Two-requester MII transmit frame scheduler: preamble/SFD, payload, underrun
// handling and inter-frame gap, all paced by the MII byte strobe.
//
// state | meaning
// IDLE  | no frame; waits for a request with the buffer not busy
// PREAM | emitting 0x55 preamble bytes
// SFD   | SFD on the line; first payload byte is taken on the next strobe
// DATA  | streaming payload bytes from the granted requester
// DRAIN | underrun seen; discarding requester bytes up to Last
// IFG   | line idle for the inter-frame gap, grant still held
module mii_tx_sched import mii_ctrl_pkg::*; #(
  parameter int DataWidth_C   = 8,
  parameter int PreambleLen_C = MII_PREAMBLE_LEN_DEF,
  parameter int IfgLen_C      = MII_IFG_LEN_DEF
) (
  input  logic                   sys_clk_i,
  input  logic                   reset_i,
  input  logic                   mii_clk_en_i,
  input  logic                   buff_busy_i,
  input  logic                   req0_valid_i,
  input  logic [DataWidth_C-1:0] req0_data_i,
  input  logic                   req0_last_i,
  output logic                   req0_ready_o,
  input  logic                   req1_valid_i,
  input  logic [DataWidth_C-1:0] req1_data_i,
  input  logic                   req1_last_i,
  output logic                   req1_ready_o,
  output logic                   mii_data_en_o,
  output logic [DataWidth_C-1:0] mii_data_o,
  output logic                   mii_err_o,
  output logic [1:0]             grant_o,
  output logic                   underrun_o
);

  localparam logic [MII_PREAMBLE_CNT_W-1:0] PreLen_C = MII_PREAMBLE_CNT_W'(PreambleLen_C);
  localparam logic [MII_IFG_CNT_W-1:0]      IfgMax_C = MII_IFG_CNT_W'(IfgLen_C);
  localparam logic [DataWidth_C-1:0]        PreByte_C = DataWidth_C'(MII_PREAMBLE_BYTE);
  localparam logic [DataWidth_C-1:0]        SfdByte_C = DataWidth_C'(MII_SFD_BYTE);

  mii_state_e                    state_q, state_d;
  logic [MII_PREAMBLE_CNT_W-1:0] pcnt_q, pcnt_d;
  logic [MII_IFG_CNT_W-1:0]      icnt_q, icnt_d, icnt_inc;
  logic                          data_en_q, data_en_d;
  logic [DataWidth_C-1:0]        data_q, data_d;
  logic                          err_q, err_d;
  logic                          underrun_q, underrun_d;

  logic [1:0]             grant;
  logic                   arb_start, arb_release;
  logic                   sel_valid, sel_last;
  logic [DataWidth_C-1:0] sel_data;
  logic                   xfer_win;

  mii_rr_arb2 u_arb (
    .clk_i     (sys_clk_i),
    .reset_i   (reset_i),
    .req_i     ({req1_valid_i, req0_valid_i}),
    .start_i   (arb_start),
    .release_i (arb_release),
    .grant_o   (grant)
  );

  assign sel_valid = (grant[0] & req0_valid_i) | (grant[1] & req1_valid_i);
  assign sel_last  = (grant[0] & req0_last_i)  | (grant[1] & req1_last_i);
  assign sel_data  = grant[1] ? req1_data_i : req0_data_i;

  // Payload is taken only on byte strobes, except while draining after an
  // underrun where the rest of the frame is flushed as fast as it arrives.
  assign xfer_win     = (((state_q == SFD) || (state_q == DATA)) && mii_clk_en_i) ||
                        (state_q == DRAIN);
  assign req0_ready_o = grant[0] & xfer_win;
  assign req1_ready_o = grant[1] & xfer_win;

  assign icnt_inc = (icnt_q >= IfgMax_C) ? icnt_q : icnt_q + 5'd1;

  // Next-state and output-register decode.
  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    icnt_d      = icnt_q;
    data_en_d   = data_en_q;
    data_d      = data_q;
    err_d       = err_q;
    underrun_d  = 1'b0;
    arb_start   = 1'b0;
    arb_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (mii_clk_en_i && !buff_busy_i && (req0_valid_i || req1_valid_i)) begin
          arb_start = 1'b1;
          state_d   = PREAM;
          data_en_d = 1'b1;
          data_d    = PreByte_C;
          err_d     = 1'b0;
          pcnt_d    = 4'd1;
        end
      end
      PREAM: begin
        if (mii_clk_en_i) begin
          data_en_d = 1'b1;
          err_d     = 1'b0;
          if (pcnt_q >= PreLen_C) begin
            data_d  = SfdByte_C;
            state_d = SFD;
          end else begin
            data_d = PreByte_C;
            pcnt_d = pcnt_q + 4'd1;
          end
        end
      end
      SFD, DATA: begin
        if (mii_clk_en_i) begin
          data_en_d = 1'b1;
          if (sel_valid) begin
            data_d  = sel_data;
            err_d   = 1'b0;
            state_d = sel_last ? IFG : DATA;
            if (sel_last) begin
              icnt_d = '0;
            end
          end else begin
            data_d     = '0;
            err_d      = 1'b1;
            underrun_d = 1'b1;
            state_d    = DRAIN;
            icnt_d     = '0;
          end
        end
      end
      DRAIN: begin
        if (mii_clk_en_i) begin
          data_en_d = 1'b0;
          data_d    = '0;
          err_d     = 1'b0;
          icnt_d    = icnt_inc;
        end
        if (sel_valid && sel_last) begin
          state_d = IFG;
        end
      end
      IFG: begin
        if (mii_clk_en_i) begin
          data_en_d = 1'b0;
          data_d    = '0;
          err_d     = 1'b0;
          icnt_d    = icnt_inc;
          if (icnt_inc >= IfgMax_C) begin
            state_d     = IDLE;
            arb_release = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered MII outputs.
  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      icnt_q     <= '0;
      data_en_q  <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      icnt_q     <= icnt_d;
      data_en_q  <= data_en_d;
      data_q     <= data_d;
      err_q      <= err_d;
      underrun_q <= underrun_d;
    end
  end

  assign mii_data_en_o = data_en_q;
  assign mii_data_o    = data_q;
  assign mii_err_o     = err_q;
  assign grant_o       = grant;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_mii_tx_sched.sv
// Directed bench for mii_tx_sched with an output-byte scoreboard.
module tb_mii_tx_sched;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic [1:0] grant;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mii_clk_en = 1'b0;
  logic       buff_busy = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [7:0] req1_data = 8'h00;
  logic       data_en, err, underrun;
  logic [7:0] data;
  logic [1:0] grant;

  int   total = 0;
  int   bad = 0;
  int   en_div = 2;
  int   cyc = 0;
  int   und_cnt = 0;
  int   en_low_run = 0;
  int   last_gap = 0;
  int   rel_run = 0;
  int   lat0 = 0;
  int   lat1 = 0;
  logic drain_ok = 1'b0;
  exp_t exp_q[$];

  mii_tx_sched dut (
    .sys_clk_i     (clk),
    .reset_i       (reset),
    .mii_clk_en_i  (mii_clk_en),
    .buff_busy_i   (buff_busy),
    .req0_valid_i  (req0_valid),
    .req0_data_i   (req0_data),
    .req0_last_i   (req0_last),
    .req0_ready_o  (req0_ready),
    .req1_valid_i  (req1_valid),
    .req1_data_i   (req1_data),
    .req1_last_i   (req1_last),
    .req1_ready_o  (req1_ready),
    .mii_data_en_o (data_en),
    .mii_data_o    (data),
    .mii_err_o     (err),
    .grant_o       (grant),
    .underrun_o    (underrun)
  );

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mii_clk_en = ((cyc % en_div) == 0);
    end
  end

  // Monitor: strobe gating of Ready, hold between strobes, scoreboard on bytes.
  initial begin
    logic [11:0] prev;
    logic        en_edge, rst_edge;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      #4;
      total++;
      assert (!((req0_ready || req1_ready) && !mii_clk_en && !drain_ok))
      else begin bad++; $error("FAIL ready_gate observed=%b%b expected=00", req1_ready, req0_ready); end
      total++;
      assert (!(req0_ready && grant != 2'b01) && !(req1_ready && grant != 2'b10))
      else begin bad++; $error("FAIL ready_owner observed=%b%b expected_grant=%b", req1_ready, req0_ready, grant); end
      @(posedge clk);
      en_edge  = mii_clk_en;
      rst_edge = reset;
      #1;
      if (underrun) und_cnt++;
      if (!rst_edge && !en_edge) begin
        total++;
        assert ({data_en, data, err, grant} === prev)
        else begin bad++; $error("FAIL hold observed=%h expected=%h", {data_en, data, err, grant}, prev); end
      end
      if (en_edge && !rst_edge) begin
        if (data_en) begin
          if (en_low_run > 0) last_gap = en_low_run;
          en_low_run = 0;
          total++;
          assert (exp_q.size() > 0)
          else begin bad++; $error("FAIL sb_extra observed=%02h expected=none", data); end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert ({data, err, grant} === {e.data, e.err, e.grant})
            else begin bad++; $error("FAIL sb_byte observed=%02h/%b/%b expected=%02h/%b/%b", data, err, grant, e.data, e.err, e.grant); end
          end
        end else begin
          en_low_run++;
          if (prev[1:0] != 2'b00 && grant == 2'b00) rel_run = en_low_run;
        end
      end
      prev = {data_en, data, err, grant};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask

  task automatic push_b(input logic [7:0] d, input logic e, input logic [1:0] g);
    exp_t x;
    x.data  = d;
    x.err   = e;
    x.grant = g;
    exp_q.push_back(x);
  endtask

  task automatic push_pre(input logic [1:0] g);
    for (int i = 0; i < 7; i++) push_b(8'h55, 1'b0, g);
    push_b(8'hD5, 1'b0, g);
  endtask

  // Present one byte and wait until the DUT takes it; lat = cycles waited.
  task automatic req_byte(input int n, input logic [7:0] d, input logic last, output int lat);
    logic rdy;
    lat = 0;
    rdy = 1'b0;
    @(negedge clk);
    if (n == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = last; end
    else        begin req1_valid = 1'b1; req1_data = d; req1_last = last; end
    forever begin
      #4;
      rdy = (n == 0) ? req0_ready : req1_ready;
      if (rdy || lat > 500) break;
      lat++;
      @(negedge clk);
    end
    total++;
    assert (rdy === 1'b1)
    else begin bad++; $error("FAIL req%0d_accept observed=%b expected=1", n, rdy); end
  endtask

  task automatic req_idle(input int n);
    @(negedge clk);
    if (n == 0) begin req0_valid = 1'b0; req0_last = 1'b0; end
    else        begin req1_valid = 1'b0; req1_last = 1'b0; end
  endtask

  task automatic en_edges(input int k);
    int c = 0;
    while (c < k) begin
      @(posedge clk);
      if (mii_clk_en) c++;
    end
    #2;
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_release(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #2;
      if (grant == 2'b00) break;
    end
    chk({tag, "_release"}, grant, 2'b00);
    chk({tag, "_ifg"}, rel_run, 12);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_en", data_en, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);

    // Single frame, strobe every 2nd cycle
    push_pre(2'b01);
    push_b(8'h11, 1'b0, 2'b01);
    push_b(8'h22, 1'b0, 2'b01);
    push_b(8'h33, 1'b0, 2'b01);
    req_byte(0, 8'h11, 1'b0, lat0);
    req_byte(0, 8'h22, 1'b0, lat0);
    req_byte(0, 8'h33, 1'b1, lat0);
    req_idle(0);
    wait_sb_empty("single_sb");
    wait_release("single");

    // Tie after reset: requester 0 first, then 1 after exactly one IFG
    pulse_reset();
    push_pre(2'b01);
    push_b(8'hA1, 1'b0, 2'b01);
    push_b(8'hA2, 1'b0, 2'b01);
    push_pre(2'b10);
    push_b(8'hB1, 1'b0, 2'b10);
    push_b(8'hB2, 1'b0, 2'b10);
    fork
      begin req_byte(0, 8'hA1, 1'b0, lat0); req_byte(0, 8'hA2, 1'b1, lat0); req_idle(0); end
      begin req_byte(1, 8'hB1, 1'b0, lat1); req_byte(1, 8'hB2, 1'b1, lat1); req_idle(1); end
    join
    wait_sb_empty("tie_sb");
    chk("tie_gap", last_gap, 12);
    wait_release("tie");
    push_pre(2'b01);
    push_b(8'hC1, 1'b0, 2'b01);
    push_pre(2'b10);
    push_b(8'hD1, 1'b0, 2'b10);
    fork
      begin req_byte(0, 8'hC1, 1'b1, lat0); req_idle(0); end
      begin req_byte(1, 8'hD1, 1'b1, lat1); req_idle(1); end
    join
    wait_sb_empty("tie3_sb");
    chk("tie3_gap", last_gap, 12);
    wait_release("tie3");

    // Underrun with drain, strobe every 4th cycle
    en_div = 4;
    drain_ok = 1'b1;
    und_cnt = 0;
    push_pre(2'b01);
    push_b(8'hAA, 1'b0, 2'b01);
    push_b(8'h00, 1'b1, 2'b01);
    req_byte(0, 8'hAA, 1'b0, lat0);
    req_idle(0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (und_cnt > 0) break;
    end
    chk("und_seen", und_cnt, 1);
    req_byte(0, 8'hBB, 1'b0, lat0);
    chk("drain_bb_lat", lat0, 0);
    req_byte(0, 8'hCC, 1'b1, lat0);
    chk("drain_cc_lat", lat0, 0);
    req_idle(0);
    wait_sb_empty("und_sb");
    wait_release("und");
    chk("und_pulse_len", und_cnt, 1);
    drain_ok = 1'b0;

    // Busy hold-off
    en_div = 2;
    push_pre(2'b10);
    push_b(8'h5A, 1'b0, 2'b10);
    @(negedge clk);
    buff_busy = 1'b1;
    req1_valid = 1'b1;
    req1_data = 8'h5A;
    req1_last = 1'b1;
    en_edges(5);
    chk("busy_grant", grant, 2'b00);
    chk("busy_en", data_en, 1'b0);
    @(negedge clk);
    buff_busy = 1'b0;
    en_edges(1);
    chk("busy_start_en", data_en, 1'b1);
    chk("busy_start_data", data, 8'h55);
    chk("busy_start_grant", grant, 2'b10);
    req_byte(1, 8'h5A, 1'b1, lat1);
    req_idle(1);
    wait_sb_empty("busy_sb");
    wait_release("busy");

    // Reset during the third payload byte, then immediate restart
    push_pre(2'b01);
    push_b(8'h01, 1'b0, 2'b01);
    push_b(8'h02, 1'b0, 2'b01);
    push_b(8'h03, 1'b0, 2'b01);
    req_byte(0, 8'h01, 1'b0, lat0);
    req_byte(0, 8'h02, 1'b0, lat0);
    req_byte(0, 8'h03, 1'b0, lat0);
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_en", data_en, 1'b0);
    chk("mrst_grant", grant, 2'b00);
    chk("mrst_err", err, 1'b0);
    chk("mrst_sb", exp_q.size(), 0);
    push_pre(2'b01);
    push_b(8'h77, 1'b0, 2'b01);
    req0_valid = 1'b1;
    req0_data = 8'h77;
    req0_last = 1'b1;
    en_edges(1);
    chk("restart_en", data_en, 1'b1);
    chk("restart_data", data, 8'h55);
    req_byte(0, 8'h77, 1'b1, lat0);
    req_idle(0);
    wait_sb_empty("restart_sb");
    wait_release("restart");

    // Strobe every 4th cycle
    en_div = 4;
    push_pre(2'b10);
    push_b(8'h9A, 1'b0, 2'b10);
    push_b(8'h9B, 1'b0, 2'b10);
    req_byte(1, 8'h9A, 1'b0, lat1);
    req_byte(1, 8'h9B, 1'b1, lat1);
    req_idle(1);
    wait_sb_empty("slow_sb");
    wait_release("slow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
